// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined main-control unit.
// Covers opcodes, bundle flag positions and the bubble value.
package ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BR2   = 6'b111110;
    localparam logic [5:0] OP_NOT   = 6'b111111;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Flag positions inside the 8-bit flag byte that sits above ALUOp.
    localparam int FLAG_W          = 8;
    localparam int IDX_SALTOINCOND = 7;
    localparam int IDX_REGDEST     = 6;
    localparam int IDX_FUENTEALU   = 5;
    localparam int IDX_MEMAREG     = 4;
    localparam int IDX_ESCRREG     = 3;
    localparam int IDX_LEERMEM     = 2;
    localparam int IDX_ESCRMEM     = 1;
    localparam int IDX_SALTOCOND   = 0;

    localparam logic [FLAG_W-1:0] BUBBLE = '0;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;
endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control-bundle decoder.
// Unknown opcodes give the bubble and raise the illegal flag.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2
) (
    input  logic                  valid,
    input  logic [OP_W-1:0]       op,
    output logic [FLAG_W+ALUOP_W-1:0] ctrl,
    output logic                  illegal
);
    logic [FLAG_W-1:0] flags;
    logic [1:0]        aluop;

    always_comb begin
        flags   = BUBBLE;
        aluop   = ALUOP_ADD;
        illegal = 1'b0;
        if (valid) begin
            case (op)
                OP_W'(OP_RTYPE): begin
                    flags[IDX_REGDEST] = 1'b1;
                    flags[IDX_ESCRREG] = 1'b1;
                    aluop              = ALUOP_FN;
                end
                OP_W'(OP_LW): begin
                    flags[IDX_FUENTEALU] = 1'b1;
                    flags[IDX_MEMAREG]   = 1'b1;
                    flags[IDX_ESCRREG]   = 1'b1;
                    flags[IDX_LEERMEM]   = 1'b1;
                end
                OP_W'(OP_SW): begin
                    flags[IDX_FUENTEALU] = 1'b1;
                    flags[IDX_ESCRMEM]   = 1'b1;
                end
                OP_W'(OP_BEQ), OP_W'(OP_BR2): begin
                    flags[IDX_SALTOCOND] = 1'b1;
                    aluop                = ALUOP_SUB;
                end
                OP_W'(OP_NOT): begin
                    flags[IDX_FUENTEALU] = 1'b1;
                    flags[IDX_ESCRREG]   = 1'b1;
                end
                OP_W'(OP_J): begin
                    flags[IDX_SALTOINCOND] = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    assign ctrl = {flags, ALUOP_W'(aluop)};
endmodule

// File: rtl/control_pipe.sv
// Pipelined main control: decodes in ID and carries the bundle through
// ID/EX, EX/MEM and MEM/WB with load-use stall and taken-branch flush.
module control_pipe
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_op,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   ex_rt,
    input  logic               br_taken,
    output logic               id_jump,
    output logic               stall,
    output logic [ALUOP_W+1:0] ex_ctrl,
    output logic [2:0]         mem_ctrl,
    output logic [1:0]         wb_ctrl,
    output logic               illegal
);
    localparam int CTRL_W = FLAG_W + ALUOP_W;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              hazard;

    // ID/EX drops the jump flag: it only matters in the decode cycle.
    logic [CTRL_W-2:0] idex_reg, idex_next;
    logic              idex_ill_reg, idex_ill_next;
    logic [4:0]        exmem_reg, exmem_next;
    logic [1:0]        memwb_reg, memwb_next;

    ctrl_decode #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .valid   (id_valid),
        .op      (id_op),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign hazard = idex_reg[ALUOP_W+IDX_LEERMEM] & idex_reg[ALUOP_W+IDX_ESCRREG]
                  & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt)) & id_valid;

    // Flush outranks the stall, so a flushed cycle never reports a stall.
    assign stall   = hazard & ~br_taken;
    assign id_jump = dec_ctrl[ALUOP_W+IDX_SALTOINCOND] & ~hazard & ~br_taken;

    always_comb begin
        idex_next     = dec_ctrl[CTRL_W-2:0];
        idex_ill_next = dec_illegal;
        if (br_taken || hazard) begin
            idex_next     = '0;
            idex_ill_next = 1'b0;
        end
        exmem_next = br_taken ? 5'b0 :
                     {idex_reg[ALUOP_W+IDX_LEERMEM], idex_reg[ALUOP_W+IDX_ESCRMEM],
                      idex_reg[ALUOP_W+IDX_SALTOCOND], idex_reg[ALUOP_W+IDX_MEMAREG],
                      idex_reg[ALUOP_W+IDX_ESCRREG]};
        memwb_next = exmem_reg[1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_reg     <= '0;
            idex_ill_reg <= 1'b0;
            exmem_reg    <= '0;
            memwb_reg    <= '0;
        end else begin
            idex_reg     <= idex_next;
            idex_ill_reg <= idex_ill_next;
            exmem_reg    <= exmem_next;
            memwb_reg    <= memwb_next;
        end
    end

    assign ex_ctrl  = {idex_reg[ALUOP_W+IDX_REGDEST], idex_reg[ALUOP_W+IDX_FUENTEALU],
                       idex_reg[ALUOP_W-1:0]};
    assign mem_ctrl = exmem_reg[4:2];
    assign wb_ctrl  = memwb_reg;
    assign illegal  = idex_ill_reg;
endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: reset, decode latency, load-use stall,
// branch flush, illegal opcodes and jump suppression.
module tb_control_pipe;
    logic       clk = 1'b0;
    logic       rst_n, id_valid, br_taken;
    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_jump, stall, illegal;
    logic [3:0] ex_ctrl;
    logic [2:0] mem_ctrl;
    logic [1:0] wb_ctrl;
    int checks = 0;
    int errors = 0;

    control_pipe #(.OP_W(6), .REG_W(5), .ALUOP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .br_taken(br_taken),
        .id_jump(id_jump), .stall(stall), .ex_ctrl(ex_ctrl),
        .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        id_valid = v; id_op = op; id_rs = rs; id_rt = rt;
        $display("txn: valid=%0d op=%b rs=%0d rt=%0d ex_rt=%0d br=%0d", v, op, rs, rt, ex_rt, br_taken);
    endtask

    task automatic idle();
        br_taken = 1'b0; ex_rt = 5'd0;
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; br_taken = 1'b0; ex_rt = 5'd0;
        set_id(1'b1, 6'b000000, 5'd1, 5'd2);
        step(); step();
        rst_n = 1'b1;
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        #1;
        checks++; if (ex_ctrl !== 4'b0000) begin errors++; $display("FAIL reset_ex: ex_ctrl=%b expected 0000", ex_ctrl); end
        checks++; if (mem_ctrl !== 3'b000) begin errors++; $display("FAIL reset_mem: mem_ctrl=%b expected 000", mem_ctrl); end
        checks++; if (wb_ctrl !== 2'b00) begin errors++; $display("FAIL reset_wb: wb_ctrl=%b expected 00", wb_ctrl); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: illegal=%b expected 0", illegal); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: stall=%b expected 0", stall); end
        set_id(1'b1, 6'b000000, 5'd1, 5'd2);
        step();
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        checks++; if (ex_ctrl !== 4'b1010) begin errors++; $display("FAIL rtype_ex: ex_ctrl=%b expected 1010", ex_ctrl); end
        step();
        checks++; if (mem_ctrl !== 3'b000) begin errors++; $display("FAIL rtype_mem: mem_ctrl=%b expected 000", mem_ctrl); end
        step();
        checks++; if (wb_ctrl !== 2'b01) begin errors++; $display("FAIL rtype_wb: wb_ctrl=%b expected 01", wb_ctrl); end
    endtask

    task automatic test_reset_mid();
        idle();
        set_id(1'b1, 6'b100011, 5'd1, 5'd5);
        step();
        set_id(1'b1, 6'b000000, 5'd1, 5'd2);
        step();
        checks++; if (mem_ctrl !== 3'b100) begin errors++; $display("FAIL mid_pre_mem: mem_ctrl=%b expected 100", mem_ctrl); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        #1;
        checks++; if (ex_ctrl !== 4'b0000) begin errors++; $display("FAIL mid_ex: ex_ctrl=%b expected 0000", ex_ctrl); end
        checks++; if (mem_ctrl !== 3'b000) begin errors++; $display("FAIL mid_mem: mem_ctrl=%b expected 000", mem_ctrl); end
        checks++; if (wb_ctrl !== 2'b00) begin errors++; $display("FAIL mid_wb: wb_ctrl=%b expected 00", wb_ctrl); end
    endtask

    task automatic test_load_use();
        idle();
        set_id(1'b1, 6'b100011, 5'd1, 5'd5);
        step();
        checks++; if (ex_ctrl !== 4'b0100) begin errors++; $display("FAIL lw_ex: ex_ctrl=%b expected 0100", ex_ctrl); end
        ex_rt = 5'd5;
        set_id(1'b1, 6'b000000, 5'd5, 5'd6);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: stall=%b expected 1", stall); end
        step();
        ex_rt = 5'd0;
        #1;
        checks++; if (ex_ctrl !== 4'b0000) begin errors++; $display("FAIL lu_bubble_ex: ex_ctrl=%b expected 0000", ex_ctrl); end
        checks++; if (mem_ctrl !== 3'b100) begin errors++; $display("FAIL lu_lw_mem: mem_ctrl=%b expected 100", mem_ctrl); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_restall: stall=%b expected 0", stall); end
        step();
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        checks++; if (ex_ctrl !== 4'b1010) begin errors++; $display("FAIL lu_issue_ex: ex_ctrl=%b expected 1010", ex_ctrl); end
        checks++; if (wb_ctrl !== 2'b11) begin errors++; $display("FAIL lu_lw_wb: wb_ctrl=%b expected 11", wb_ctrl); end
    endtask

    task automatic test_no_dep();
        idle();
        set_id(1'b1, 6'b100011, 5'd1, 5'd0);
        step();
        ex_rt = 5'd0;
        set_id(1'b1, 6'b000000, 5'd0, 5'd0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall: stall=%b expected 0", stall); end
        ex_rt = 5'd5;
        set_id(1'b1, 6'b000000, 5'd3, 5'd3);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nodep_stall: stall=%b expected 0", stall); end
        set_id(1'b1, 6'b000000, 5'd3, 5'd5);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rt_dep_stall: stall=%b expected 1", stall); end
        set_id(1'b0, 6'b000000, 5'd3, 5'd5);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL invalid_stall: stall=%b expected 0", stall); end
    endtask

    task automatic test_store_br2();
        idle();
        set_id(1'b1, 6'b101011, 5'd1, 5'd2);
        step();
        set_id(1'b1, 6'b111110, 5'd1, 5'd2);
        checks++; if (ex_ctrl !== 4'b0100) begin errors++; $display("FAIL sw_ex: ex_ctrl=%b expected 0100", ex_ctrl); end
        step();
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        checks++; if (mem_ctrl !== 3'b010) begin errors++; $display("FAIL sw_mem: mem_ctrl=%b expected 010", mem_ctrl); end
        checks++; if (ex_ctrl !== 4'b0001) begin errors++; $display("FAIL br2_ex: ex_ctrl=%b expected 0001", ex_ctrl); end
        step();
        checks++; if (mem_ctrl !== 3'b001) begin errors++; $display("FAIL br2_mem: mem_ctrl=%b expected 001", mem_ctrl); end
    endtask

    task automatic test_branch_flush();
        idle();
        set_id(1'b1, 6'b000100, 5'd1, 5'd2);
        step();
        checks++; if (ex_ctrl !== 4'b0001) begin errors++; $display("FAIL beq_ex: ex_ctrl=%b expected 0001", ex_ctrl); end
        set_id(1'b1, 6'b100011, 5'd1, 5'd5);
        step();
        checks++; if (mem_ctrl !== 3'b001) begin errors++; $display("FAIL beq_mem: mem_ctrl=%b expected 001", mem_ctrl); end
        ex_rt = 5'd5; br_taken = 1'b1;
        set_id(1'b1, 6'b000000, 5'd5, 5'd6);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: stall=%b expected 0", stall); end
        step();
        br_taken = 1'b0; ex_rt = 5'd0;
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        #1;
        checks++; if (ex_ctrl !== 4'b0000) begin errors++; $display("FAIL flush_ex: ex_ctrl=%b expected 0000", ex_ctrl); end
        checks++; if (mem_ctrl !== 3'b000) begin errors++; $display("FAIL flush_mem: mem_ctrl=%b expected 000", mem_ctrl); end
        checks++; if (wb_ctrl !== 2'b00) begin errors++; $display("FAIL flush_wb: wb_ctrl=%b expected 00", wb_ctrl); end
    endtask

    task automatic test_illegal();
        idle();
        set_id(1'b1, 6'b101010, 5'd1, 5'd2);
        step();
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_set: illegal=%b expected 1", illegal); end
        checks++; if (ex_ctrl !== 4'b0000) begin errors++; $display("FAIL ill_ex: ex_ctrl=%b expected 0000", ex_ctrl); end
        step();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_clear: illegal=%b expected 0", illegal); end
        checks++; if (mem_ctrl !== 3'b000) begin errors++; $display("FAIL ill_mem: mem_ctrl=%b expected 000", mem_ctrl); end
        set_id(1'b1, 6'b111111, 5'd1, 5'd2);
        step();
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        checks++; if (ex_ctrl !== 4'b0100) begin errors++; $display("FAIL not_ex: ex_ctrl=%b expected 0100", ex_ctrl); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL not_illegal: illegal=%b expected 0", illegal); end
        step(); step();
        checks++; if (wb_ctrl !== 2'b01) begin errors++; $display("FAIL not_wb: wb_ctrl=%b expected 01", wb_ctrl); end
        set_id(1'b0, 6'b101010, 5'd0, 5'd0);
        step();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_invalid: illegal=%b expected 0", illegal); end
    endtask

    task automatic test_back_to_back();
        idle();
        set_id(1'b1, 6'b101010, 5'd1, 5'd2);
        step();
        set_id(1'b1, 6'b111000, 5'd1, 5'd2);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL b2b_first: illegal=%b expected 1", illegal); end
        step();
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL b2b_second: illegal=%b expected 1", illegal); end
        step();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL b2b_end: illegal=%b expected 0", illegal); end
    endtask

    task automatic test_jump();
        idle();
        set_id(1'b1, 6'b000010, 5'd0, 5'd0);
        #1;
        checks++; if (id_jump !== 1'b1) begin errors++; $display("FAIL jump_set: id_jump=%b expected 1", id_jump); end
        br_taken = 1'b1;
        #1;
        checks++; if (id_jump !== 1'b0) begin errors++; $display("FAIL jump_br: id_jump=%b expected 0", id_jump); end
        br_taken = 1'b0;
        set_id(1'b1, 6'b100011, 5'd1, 5'd5);
        step();
        ex_rt = 5'd5;
        set_id(1'b1, 6'b000010, 5'd5, 5'd0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL jump_stall: stall=%b expected 1", stall); end
        checks++; if (id_jump !== 1'b0) begin errors++; $display("FAIL jump_stalled: id_jump=%b expected 0", id_jump); end
        step();
        ex_rt = 5'd0;
        #1;
        checks++; if (id_jump !== 1'b1) begin errors++; $display("FAIL jump_retry: id_jump=%b expected 1", id_jump); end
        step();
        set_id(1'b0, 6'b000000, 5'd0, 5'd0);
        checks++; if (ex_ctrl !== 4'b0000) begin errors++; $display("FAIL jump_ex: ex_ctrl=%b expected 0000", ex_ctrl); end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_load_use();
        test_no_dep();
        test_store_br2();
        test_branch_flush();
        test_illegal();
        test_back_to_back();
        test_jump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_pipe.md
# control_pipe

Parametrised pipelined main-control unit for the segmented processor. It decodes the ID-stage opcode into the 10-bit control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and inserts bubbles, and flushes wrong-path instructions on a taken branch. It sits beside the datapath pipeline registers and replaces the purely combinational decoder.

## Interface
Parameters:
- OP_W, 6, opcode width.
- REG_W, 5, register-address width.
- ALUOP_W, 2, ALUOp field width. Bundle width is CTRL_W = 8 + ALUOP_W.

Ports (`clk` and `rst_n` are decided: one clock, synchronous active-low reset):
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low; sampled on the `clk` rising edge.
- id_valid  in  1  ID stage holds a real instruction.
- id_op  in  OP_W  opcode of the ID instruction.
- id_rs, id_rt  in  REG_W each  source registers of the ID instruction.
- ex_rt  in  REG_W  rt field of the instruction in EX, from the datapath ID/EX register.
- br_taken  in  1  branch resolved taken in MEM.
- id_jump  out  1  Saltoincond of the current decode (combinational).
- stall  out  1  hold PC and IF/ID this cycle.
- ex_ctrl  out  2+ALUOP_W  {RegDest, FuenteALU, ALUOp} of the EX instruction.
- mem_ctrl  out  3  {LeerMem, EscrMem, SaltoCond} of the MEM instruction.
- wb_ctrl  out  2  {MemaReg, EscrReg} of the WB instruction.
- illegal  out  1  registered; set for 1 cycle after an undefined opcode enters EX.

## Operation
- Bundle bit order, MSB to LSB: Saltoincond, RegDest, FuenteALU, MemaReg, EscrReg, LeerMem, EscrMem, SaltoCond, ALUOp.
- Decode, with ALUOp zero-extended to ALUOP_W:
  - 000000 R-type: 0100100010.
  - 100011 load: 0011110000.
  - 101011 store: 0010001000.
  - 000100 beq: 0000000101.
  - 111110 branch variant: 0000000101.
  - 111111 not: 0010100000.
  - 000010 jump: 1000000000.
- Undefined opcode decodes to all-zero (bubble) and raises `illegal` when it reaches EX. No X values are ever driven.
- `id_valid`=0 decodes to the bubble.
- Load-use hazard: `stall` = EX.LeerMem & EX.EscrReg & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt) & id_valid.
- On stall, ID/EX loads the bubble. EX/MEM and MEM/WB advance normally. `id_jump` is forced to 0.
- On `br_taken`, ID/EX and EX/MEM load the bubble; the two younger instructions are discarded. MEM/WB advances normally, so the branch itself retires. `stall` and `id_jump` are forced to 0 that cycle.
- Update priority: reset > `br_taken` > `stall` > normal advance.

## Timing
- Latency: ID decode appears on `ex_ctrl` 1 cycle later, on `mem_ctrl` after 2 cycles, on `wb_ctrl` after 3 cycles.
- `stall` and `id_jump` are combinational from the current inputs and the EX register, within the same cycle.
- A load followed immediately by a dependent instruction produces exactly 1 stall cycle. The dependent instruction re-decodes the next cycle with no stall.
- Reset: all pipeline registers are cleared to the bubble. `ex_ctrl`, `mem_ctrl`, `wb_ctrl` and `illegal` are 0 on the first cycle after reset. Reset asserted mid-operation discards all in-flight control on that edge.
- `br_taken` and `stall` in the same cycle: flush wins and `stall` reads 0.
- A dependency through register 0 never stalls.
- Back-to-back undefined opcodes give `illegal` high on consecutive cycles.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BR2, OP_NOT, OP_J;
  - bundle bit-index constants;
  - the BUBBLE constant.
- One sub-module, `ctrl_decode`: the combinational opcode-to-bundle plus illegal flag. `control_pipe` instantiates it and owns the three pipeline registers and the hazard/flush logic.

## Test plan
- Reset: assert `rst_n`=0 with opcode 000000 applied → after release, all outputs are 0. On the first valid R-type, `ex_ctrl`=1010 next cycle, `wb_ctrl`=01 three cycles after decode.
- Load-use: lw with ex_rt=5, then id_rs=5 → `stall`=1 for exactly one cycle, `ex_ctrl`=0 on the following cycle, then the dependent instruction issues.
- Register-0 / no-dependency: lw with ex_rt=0, or id_rs=id_rt≠ex_rt → `stall` stays 0.
- Branch flush: beq in MEM with `br_taken`=1, and a load-use condition true in the same cycle → `stall`=0, next `ex_ctrl`=0, next `mem_ctrl`=000, `wb_ctrl` still follows the beq (00).
- Illegal opcode: 101010 → `illegal`=1 for one cycle, all bundle fields 0 down the pipe. Then 111111 → `ex_ctrl`=0100, `wb_ctrl`=01.
- Jump: opcode 000010 → `id_jump`=1 same cycle. With a stall or `br_taken` active in that cycle → `id_jump`=0.
